// File: rtl/apb_uart_arbiter.sv
// Round-robin arbiter sharing the UART APB slave port between two word requesters.
// Latency: accept in t, SETUP t+1, ACCESS t+2, rsp_valid pulse in t+3; back-to-back gives one transfer per 2 cycles.
// Backpressure: req_ready_o is combinational and only asserted in IDLE/ACCESS; a losing requester holds valid until granted.
//
// Ports:
//   clk, rst_                      clock, asynchronous active-low reset
//   req_valid_i/req_write_i        per-requester request valid and direction (bit n = requester n)
//   req_addr_i/req_wdata_i         per-requester payload, requester n in slice [n*W +: W]
//   req_ready_o                    one-hot accept strobe (or zero)
//   rsp_valid_o/rsp_rdata_o        one-cycle completion pulse to the owner, read data (0 for writes)
//   busy_o                         high while the APB bus is in SETUP or ACCESS
//   paddr_o/pwdata_o/pwrite_o/psel_o/penable_o/prdata_i   APB master side (no PREADY)
module apb_uart_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [1:0]          req_valid_i,
    input  logic [1:0]          req_write_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    output logic [1:0]          req_ready_o,
    output logic [1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic [DATA_W-1:0]   pwdata_o,
    output logic                pwrite_o,
    output logic                psel_o,
    output logic                penable_o,
    input  logic [DATA_W-1:0]   prdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state;
    logic                last_grant;
    logic                grant_id;

    logic                accept;
    logic                winner;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_write;

    // Arbitration is open in IDLE and in ACCESS; the latter lets a new
    // transfer follow directly without an idle cycle.
    always_comb begin
        accept = ((state == IDLE) || (state == ACCESS)) && (|req_valid_i);
        case (req_valid_i)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last_grant;  // both valid: the one not served last
        endcase
        win_addr  = winner ? req_addr_i[ADDR_W +: ADDR_W]  : req_addr_i[0 +: ADDR_W];
        win_wdata = winner ? req_wdata_i[DATA_W +: DATA_W] : req_wdata_i[0 +: DATA_W];
        win_write = winner ? req_write_i[1] : req_write_i[0];
        req_ready_o = 2'b00;
        if (accept) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // psel is registered alongside the state, so it is exactly "not IDLE".
    assign busy_o = psel_o;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            rsp_valid_o <= 2'b00;
            rsp_rdata_o <= '0;
            last_grant  <= 1'b1;    // requester 0 wins the first contention
            grant_id    <= 1'b0;
        end else begin
            rsp_valid_o <= 2'b00;

            // Payload is captured only on accept, so it stays stable through
            // SETUP/ACCESS and keeps its last value while idle.
            if (accept) begin
                paddr_o    <= win_addr;
                pwdata_o   <= win_wdata;
                pwrite_o   <= win_write;
                grant_id   <= winner;
                last_grant <= winner;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SETUP;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_o <= 1'b1;
                end
                ACCESS: begin
                    // Completion uses the grant_id of the finishing transfer;
                    // a back-to-back accept updates grant_id on this same edge.
                    rsp_valid_o[grant_id] <= 1'b1;
                    rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                    if (accept) begin
                        state     <= SETUP;
                        penable_o <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
module tb_apb_uart_arbiter;

    logic        clk;
    logic        rst_;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_write_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        busy_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;

    int checks;
    int failures;

    apb_uart_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .busy_o      (busy_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pwrite_o    (pwrite_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .prdata_i    (prdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_ = 1'b0;
        req_valid_i = 2'b00; req_write_i = 2'b00;
        req_addr_i = '0; req_wdata_i = '0; prdata_i = '0;
        step(); step();
        @(negedge clk);
        checks++; if ({psel_o, penable_o, pwrite_o, busy_o} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b want=0000", {psel_o, penable_o, pwrite_o, busy_o}); end
        checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid_o); end
        checks++; if ({paddr_o, pwdata_o, rsp_rdata_o} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h want=0", {paddr_o, pwdata_o, rsp_rdata_o}); end
        step();
        rst_ = 1'b1;
        step();
    endtask

    task automatic test_single_read;
        req_valid_i = 2'b01; req_write_i = 2'b00;
        req_addr_i[31:0] = 32'h0000_0004; prdata_i = 32'h0000_00A5;
        @(negedge clk);
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL rd_ready got=%b want=01", req_ready_o); end
        checks++; if (psel_o !== 1'b0) begin failures++; $display("FAIL rd_psel_t got=%b want=0", psel_o); end
        step();
        req_valid_i = 2'b00;
        @(negedge clk);
        checks++; if ({psel_o, penable_o, pwrite_o, busy_o} !== 4'b1001) begin failures++; $display("FAIL rd_setup got=%b want=1001", {psel_o, penable_o, pwrite_o, busy_o}); end
        checks++; if (paddr_o !== 32'h4) begin failures++; $display("FAIL rd_paddr got=%h want=4", paddr_o); end
        step();
        @(negedge clk);
        checks++; if ({psel_o, penable_o} !== 2'b11) begin failures++; $display("FAIL rd_access got=%b want=11", {psel_o, penable_o}); end
        checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rd_early_rsp got=%b want=00", rsp_valid_o); end
        step();
        @(negedge clk);
        checks++; if (rsp_valid_o !== 2'b01) begin failures++; $display("FAIL rd_rsp_valid got=%b want=01", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'hA5) begin failures++; $display("FAIL rd_rdata got=%h want=a5", rsp_rdata_o); end
        checks++; if ({psel_o, busy_o} !== 2'b00) begin failures++; $display("FAIL rd_done_idle got=%b want=00", {psel_o, busy_o}); end
        step();
        @(negedge clk);
        checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rd_rsp_pulse got=%b want=00", rsp_valid_o); end
        step();
    endtask

    task automatic test_single_write;
        req_valid_i = 2'b10; req_write_i = 2'b10;
        req_addr_i[63:32] = 32'h0000_0000; req_wdata_i[63:32] = 32'h0000_0055;
        prdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (req_ready_o !== 2'b10) begin failures++; $display("FAIL wr_ready got=%b want=10", req_ready_o); end
        step();
        req_valid_i = 2'b00; req_write_i = 2'b00;
        @(negedge clk);
        checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b101) begin failures++; $display("FAIL wr_setup got=%b want=101", {psel_o, penable_o, pwrite_o}); end
        checks++; if ({paddr_o, pwdata_o} !== {32'h0, 32'h55}) begin failures++; $display("FAIL wr_setup_data got=%h want=0/55", {paddr_o, pwdata_o}); end
        step();
        @(negedge clk);
        checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b111) begin failures++; $display("FAIL wr_access got=%b want=111", {psel_o, penable_o, pwrite_o}); end
        checks++; if (pwdata_o !== 32'h55) begin failures++; $display("FAIL wr_access_data got=%h want=55", pwdata_o); end
        step();
        @(negedge clk);
        checks++; if (rsp_valid_o !== 2'b10) begin failures++; $display("FAIL wr_rsp_valid got=%b want=10", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL wr_rdata got=%h want=0", rsp_rdata_o); end
        step();
    endtask

    task automatic test_contention;
        int rem[2];
        int exp_seq[8];
        logic [1:0]  rdy;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rsp;
        logic        exp_psel;
        logic        exp_pen;
        logic [31:0] exp_addr;
        int g;
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
        rem[0] = 4; rem[1] = 4;
        prdata_i = 32'h0000_005A;
        req_write_i = 2'b00;
        for (int c = 0; c < 18; c++) begin
            for (int n = 0; n < 2; n++) begin
                req_valid_i[n] = (rem[n] > 0);
                req_addr_i[n*32 +: 32] = (n == 1 ? 32'h200 : 32'h100) + 32'(4 * (4 - rem[n]));
            end
            @(negedge clk);
            exp_ready = (c % 2 == 0 && c < 16) ? (2'b01 << exp_seq[c/2]) : 2'b00;
            exp_psel  = (c >= 1 && c <= 16);
            exp_pen   = (c >= 2 && c <= 16 && c % 2 == 0);
            exp_rsp   = (c >= 3 && c % 2 == 1) ? (2'b01 << exp_seq[(c-3)/2]) : 2'b00;
            checks++; if (req_ready_o !== exp_ready) begin failures++; $display("FAIL cont_ready c=%0d got=%b want=%b", c, req_ready_o, exp_ready); end
            checks++; if ({psel_o, penable_o} !== {exp_psel, exp_pen}) begin failures++; $display("FAIL cont_bus c=%0d got=%b want=%b", c, {psel_o, penable_o}, {exp_psel, exp_pen}); end
            checks++; if (rsp_valid_o !== exp_rsp) begin failures++; $display("FAIL cont_rsp c=%0d got=%b want=%b", c, rsp_valid_o, exp_rsp); end
            if (exp_rsp != 2'b00) begin
                checks++; if (rsp_rdata_o !== 32'h5A) begin failures++; $display("FAIL cont_rdata c=%0d got=%h want=5a", c, rsp_rdata_o); end
            end
            if (c % 2 == 1 && c <= 15) begin
                g = (c - 1) / 2;
                exp_addr = (exp_seq[g] == 1 ? 32'h200 : 32'h100) + 32'(4 * (g / 2));
                checks++; if (paddr_o !== exp_addr) begin failures++; $display("FAIL cont_paddr c=%0d got=%h want=%h", c, paddr_o, exp_addr); end
            end
            rdy = req_ready_o;
            step();
            for (int n = 0; n < 2; n++) begin
                if (rdy[n]) rem[n]--;
            end
        end
        req_valid_i = 2'b00;
        checks++; if (rem[0] != 0 || rem[1] != 0) begin failures++; $display("FAIL cont_remaining got=%0d/%0d want=0/0", rem[0], rem[1]); end
    endtask

    task automatic test_back_to_back;
        req_write_i = 2'b00;
        req_valid_i = 2'b01; req_addr_i[31:0] = 32'h8; prdata_i = 32'h11;
        @(negedge clk);
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL b2b_ready0 got=%b want=01", req_ready_o); end
        step();
        req_addr_i[31:0] = 32'hC;  // second request follows immediately
        @(negedge clk);
        checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL b2b_setup_ready got=%b want=00", req_ready_o); end
        checks++; if ({psel_o, penable_o, paddr_o} !== {2'b10, 32'h8}) begin failures++; $display("FAIL b2b_setup1 got=%h want=2_00000008", {psel_o, penable_o, paddr_o}); end
        step();
        @(negedge clk);
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL b2b_ready1 got=%b want=01", req_ready_o); end
        checks++; if ({psel_o, penable_o, paddr_o} !== {2'b11, 32'h8}) begin failures++; $display("FAIL b2b_access1 got=%h want=3_00000008", {psel_o, penable_o, paddr_o}); end
        step();
        req_valid_i = 2'b00; prdata_i = 32'h22;
        @(negedge clk);
        checks++; if ({psel_o, penable_o, busy_o, paddr_o} !== {3'b101, 32'hC}) begin failures++; $display("FAIL b2b_setup2 got=%h want=5_0000000c", {psel_o, penable_o, busy_o, paddr_o}); end
        checks++; if ({rsp_valid_o, rsp_rdata_o} !== {2'b01, 32'h11}) begin failures++; $display("FAIL b2b_rsp1 got=%h want=1_00000011", {rsp_valid_o, rsp_rdata_o}); end
        step();
        @(negedge clk);
        checks++; if ({psel_o, penable_o} !== 2'b11) begin failures++; $display("FAIL b2b_access2 got=%b want=11", {psel_o, penable_o}); end
        step();
        @(negedge clk);
        checks++; if ({rsp_valid_o, rsp_rdata_o} !== {2'b01, 32'h22}) begin failures++; $display("FAIL b2b_rsp2 got=%h want=1_00000022", {rsp_valid_o, rsp_rdata_o}); end
        step();
    endtask

    task automatic test_idle_gap;
        int busy_cnt;
        req_valid_i = 2'b00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if ({req_ready_o, psel_o, rsp_valid_o, busy_o} !== 6'b0) begin failures++; $display("FAIL idle_quiet c=%0d got=%b want=000000", c, {req_ready_o, psel_o, rsp_valid_o, busy_o}); end
            step();
        end
        req_valid_i = 2'b10; req_write_i = 2'b10;
        req_addr_i[63:32] = 32'h10; req_wdata_i[63:32] = 32'h77;
        busy_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy_o === 1'b1) busy_cnt++;
            if (c == 3) begin
                checks++; if (rsp_valid_o !== 2'b10) begin failures++; $display("FAIL idle_rsp got=%b want=10", rsp_valid_o); end
            end
            step();
            req_valid_i = 2'b00; req_write_i = 2'b00;
        end
        checks++; if (busy_cnt != 2) begin failures++; $display("FAIL idle_busy_cycles got=%0d want=2", busy_cnt); end
    endtask

    task automatic test_reset_access;
        req_write_i = 2'b00;
        req_valid_i = 2'b01; req_addr_i[31:0] = 32'h30;
        @(negedge clk);
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL rst_pre_ready got=%b want=01", req_ready_o); end
        step();
        req_valid_i = 2'b00;
        step();                      // now in ACCESS
        #2;
        rst_ = 1'b0;
        #1;
        checks++; if ({psel_o, penable_o, busy_o, rsp_valid_o} !== 5'b0) begin failures++; $display("FAIL rst_async_drop got=%b want=00000", {psel_o, penable_o, busy_o, rsp_valid_o}); end
        step();
        @(negedge clk);
        checks++; if ({psel_o, rsp_valid_o} !== 3'b0) begin failures++; $display("FAIL rst_no_rsp got=%b want=000", {psel_o, rsp_valid_o}); end
        step();
        rst_ = 1'b1;
        req_valid_i = 2'b11; req_addr_i[31:0] = 32'h40; req_addr_i[63:32] = 32'h50;
        prdata_i = 32'h33;
        @(negedge clk);
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL rst_prio got=%b want=01", req_ready_o); end
        step();
        req_valid_i = 2'b00;
        @(negedge clk);
        checks++; if ({psel_o, paddr_o} !== {1'b1, 32'h40}) begin failures++; $display("FAIL rst_post_setup got=%h want=1_00000040", {psel_o, paddr_o}); end
        step(); step();
        @(negedge clk);
        checks++; if ({rsp_valid_o, rsp_rdata_o} !== {2'b01, 32'h33}) begin failures++; $display("FAIL rst_post_rsp got=%h want=1_00000033", {rsp_valid_o, rsp_rdata_o}); end
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_idle_gap();
        test_reset_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_uart_arbiter.md
Name: apb_uart_arbiter

Overview:
- Two-requester APB master arbiter that shares the single APB slave port of the UART, for example between the testbench CPU-model sequencer and a DMA-style stream agent.
- Accepts word read/write requests on valid/ready channels, grants one requester at a time by round-robin, and drives the APB SETUP/ACCESS sequence.
- Returns read data to the granted requester.
- The UART APB port has no PREADY, so every transfer is a fixed two-phase access.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.

Ports:
- clk  input  1  APB clock; all logic on its rising edge.
- rst_  input  1  reset, asynchronous, active-low.
- req_valid_i  input  2  per-requester request valid; bit n = requester n.
- req_write_i  input  2  per-requester direction; 1 = write, 0 = read.
- req_addr_i  input  2*ADDR_W  per-requester address; requester n in slice [n*ADDR_W +: ADDR_W].
- req_wdata_i  input  2*DATA_W  per-requester write data, sliced the same way.
- req_ready_o  output  2  request accepted this cycle; one-hot or zero.
- rsp_valid_o  output  2  one-cycle completion pulse to the owning requester.
- rsp_rdata_o  output  DATA_W  read data, valid while any rsp_valid_o bit is set.
- busy_o  output  1  high while an APB transfer is in SETUP or ACCESS.
- paddr_o  output  ADDR_W  APB address.
- pwdata_o  output  DATA_W  APB write data.
- pwrite_o  output  1  APB direction.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- prdata_i  input  DATA_W  APB read data from the UART.

Behaviour:
- Reset (rst_ low, asynchronous):
  - State IDLE.
  - psel_o, penable_o, pwrite_o, busy_o, rsp_valid_o all 0.
  - paddr_o, pwdata_o, rsp_rdata_o all 0.
  - last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- Arbitration happens only in IDLE or ACCESS, and only when some req_valid_i bit is set.
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than last_grant wins.
  - req_ready_o is combinational: the winner's bit is 1 in that same cycle.
  - On that edge the FSM latches the winner's addr/wdata/write into paddr_o/pwdata_o/pwrite_o, records grant_id, sets last_grant = winner, and moves to SETUP.
- Transitions:
  - IDLE -> SETUP on accept; otherwise stay in IDLE.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> SETUP if a new request is accepted in that cycle (back-to-back), otherwise ACCESS -> IDLE.
- paddr_o, pwdata_o and pwrite_o hold stable from SETUP through ACCESS. They keep their last value in IDLE.
- Completion:
  - On the edge that ends ACCESS, rsp_rdata_o <= prdata_i for reads, or 0 for writes.
  - rsp_valid_o[grant_id] <= 1 for exactly one cycle.
- Timing:
  - Accept in cycle t; SETUP in t+1; ACCESS in t+2; rsp_valid in t+3.
  - Sustained throughput is one transfer per 2 cycles.
- busy_o = (state != IDLE).
- Requester rules:
  - A requester holds valid and its payload stable until ready.
  - Payload changes while valid && !ready are undefined and are not checked.
  - A requester may assert a new valid in the same cycle its rsp_valid pulses.
- A requester whose ready is low keeps waiting; round-robin guarantees service within one transfer of a competing request.
- req_ready_o is never asserted in SETUP.
- Reset mid-transfer: the bus drops to idle asynchronously, no rsp_valid is issued, and the pending transfer is lost.

Test Plan:
- Single read: req0 read at 0x0000_0004, UART prdata=0x0000_00A5 -> ready0 at t, psel at t+1, penable at t+2, rsp_valid_o=2'b01 and rsp_rdata=0xA5 at t+3.
- Single write: req1 write 0x0000_0055 to 0x0000_0000 -> pwrite=1, pwdata=0x55 in SETUP and ACCESS; rsp_valid_o=2'b10 with rdata=0.
- Contention: both valid continuously, four requests each -> grants alternate 0,1,0,1,...; first grant goes to requester 0; transfers back-to-back with psel held high and penable toggling 0/1.
- Back-to-back same requester: req0 issues reads at 0x8 then 0xC with no gap -> second ready lands in the first ACCESS cycle, and no IDLE cycle appears between the transfers.
- Idle gaps: a single request after 10 idle cycles -> no ready, psel or rsp_valid glitches during the idle cycles; busy_o high for exactly 2 cycles.
- Reset during ACCESS: drop rst_ mid-cycle -> psel, penable and busy go 0 immediately with no rsp_valid; after release, requester 0 has priority again.
